dmem_run_ctrl: RTL and testbench
================================

// Module: dmem_run_ctrl
// PURPOSE
//  Run controller and data-memory arbiter for the single-cycle core. Holds the
//  core in reset while a host (testbench/loader) preloads dmem, then starts it
//  and gives the core sole ownership of dmem until it raises done or times out.
//  The host then gets dmem back to read the results. Sits between core and dmem.
// PARAMETERS
//  AW         8     dmem address width
//  DW         8     dmem data width
//  CW         16    run-cycle counter width
//  MAX_CYCLES 4096  watchdog limit in RUN cycles; must be 2..2**CW-1
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  reset        in   1   asynchronous, active-low reset
//  start        in   1   request a program run (single-cycle pulse)
//  host_req     in   1   host requests a dmem access this cycle
//  host_we      in   1   host access is a write
//  host_addr    in   AW  host dmem address
//  host_wdata   in   DW  host write data
//  host_gnt     out  1   host access accepted this cycle
//  host_rdata   out  DW  dmem read data for the host
//  core_rst     out  1   active-high hold-in-reset to the core
//  core_done    in   1   core done flag
//  core_we      in   1   core store enable
//  core_addr    in   AW  core dmem address
//  core_wdata   in   DW  core store data
//  core_rdata   out DW   dmem read data for the core
//  dm_we        out  1   dmem write enable
//  dm_addr      out  AW  dmem address
//  dm_di        out  DW  dmem write data
//  dm_dout      in   DW  dmem read data (combinational read)
//  busy         out  1   state is PRIME or RUN
//  finished     out  1   state is DONE
//  timeout      out  1   state is TOUT
//  cycle_cnt    out  CW  RUN cycles counted in the last or current run
// BEHAVIOUR
//  States: IDLE, PRIME, RUN, DONE, TOUT. Reset (reset=0) is async. It forces
//   IDLE and cycle_cnt=0. In IDLE, core_rst=1 and all other outputs are 0,
//   except host_gnt and host_rdata, which follow the comb rules below.
//  Ownership: the host owns dmem in IDLE, DONE and TOUT. The core owns it in
//   RUN. Nobody owns it in PRIME.
//  host_gnt = host_req & host-owned state. This is combinational, in the same
//   cycle. The host must hold its request until it sees host_gnt.
//  Host-owned: dm_we = host_gnt & host_we; dm_addr = host_addr;
//   dm_di = host_wdata; host_rdata = dm_dout; core_rdata = 0.
//   A write commits at the clock edge of the granted cycle.
//  RUN: dm_we = core_we; dm_addr = core_addr; dm_di = core_wdata;
//   core_rdata = dm_dout; host_rdata = 0.
//  PRIME: dm_we = 0, dm_addr = 0, dm_di = 0, both rdata outputs = 0.
//  core_rst = 1 in every state except RUN. While core_rst = 1, core stores
//   cannot reach dmem.
//  IDLE/DONE/TOUT + start -> PRIME. A host access in that same cycle is
//   still granted and committed.
//  PRIME -> RUN unconditionally after 1 cycle; cycle_cnt <= 0 in PRIME.
//   finished and timeout clear on entry to PRIME.
//  RUN: cycle_cnt increments by 1 every cycle and saturates at 2**CW-1.
//   - core_done=1 -> DONE; the count includes that cycle.
//   - otherwise, if cycle_cnt == MAX_CYCLES-1 -> TOUT.
//   - If both happen in the same cycle, done wins (DONE).
//   - start is ignored in PRIME and RUN.
//  DONE and TOUT hold until the next start. cycle_cnt is frozen there.
//  Latency: start edge to first core cycle (core_rst=0) = 2 clocks.
//  Reset asserted mid-RUN: state goes immediately to IDLE, core_rst=1, and
//   dm_we=0 combinationally. A store in flight is dropped.
// TESTING
//  1 Reset: reset=0 mid-RUN -> same cycle: core_rst=1, dm_we=0, busy=0;
//    after release: IDLE, cycle_cnt=0.
//  2 Preload: host writes 8'hA5 to 8'h10 in IDLE -> host_gnt=1, dm_we=1;
//    reading back 8'h10 gives host_rdata=8'hA5.
//  3 Run: start at cycle t -> core_rst=0 at t+2; core_done held high at the
//    10th RUN cycle -> finished=1, cycle_cnt=10, core_rst=1 again.
//  4 Contention: host_req=1 and core_we=1 during RUN -> host_gnt=0, dm_addr =
//    core_addr; host_gnt=1 in the first DONE cycle.
//  5 Watchdog: MAX_CYCLES=16, core_done never asserted -> timeout=1 after
//    16 RUN cycles; with core_done=1 on cycle 16 -> finished=1, timeout=0.
//  6 Restart: start in DONE -> finished clears, the core runs again, and
//    start pulses during RUN have no effect.

Source files
------------

// File: rtl/dmem_run_ctrl.sv
// Run controller and dmem arbiter: holds the core in reset while the host
// preloads dmem, then hands dmem to the core until it finishes or times out.
module dmem_run_ctrl #(
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 8,
  parameter int unsigned CW         = 16,
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          core_rst,
  input  logic          core_done,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_di,
  input  logic [DW-1:0] dm_dout,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_TOUT  = 3'd4
  } state_e;

  localparam logic [CW-1:0] CNT_SAT = '1;
  localparam logic [CW-1:0] WD_LAST = CW'(MAX_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          host_own;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Run-cycle counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Next-state and counter update; done has priority over the watchdog
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE, S_TOUT: begin
        if (start) state_d = S_PRIME;
      end
      S_PRIME: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
      S_RUN: begin
        if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
        if (core_done) begin
          state_d = S_DONE;
        end else if (cnt_q == WD_LAST) begin
          state_d = S_TOUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode and dmem mux; PRIME leaves dmem idle with no owner
  always_comb begin
    host_own   = 1'b0;
    host_gnt   = 1'b0;
    host_rdata = '0;
    core_rdata = '0;
    core_rst   = 1'b1;
    dm_we      = 1'b0;
    dm_addr    = '0;
    dm_di      = '0;
    busy       = 1'b0;
    finished   = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_TOUT: begin
        host_own = 1'b1;
      end
      S_PRIME: begin
        busy = 1'b1;
      end
      S_RUN: begin
        busy       = 1'b1;
        core_rst   = 1'b0;
        dm_we      = core_we;
        dm_addr    = core_addr;
        dm_di      = core_wdata;
        core_rdata = dm_dout;
      end
      default: ;
    endcase
    if (host_own) begin
      host_gnt   = host_req;
      dm_we      = host_req & host_we;
      dm_addr    = host_addr;
      dm_di      = host_wdata;
      host_rdata = dm_dout;
    end
    finished = (state_q == S_DONE);
    timeout  = (state_q == S_TOUT);
  end

  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_run_ctrl.sv
// Bench for dmem_run_ctrl: behavioural dmem, directed stimulus, and a monitor
// that scores host reads, run results and start latency against queued values.
module tb_dmem_run_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        host_gnt;
  logic [7:0]  host_rdata;
  logic        core_rst;
  logic        core_done = 1'b0;
  logic        core_we = 1'b0;
  logic [7:0]  core_addr = '0;
  logic [7:0]  core_wdata = '0;
  logic [7:0]  core_rdata;
  logic        dm_we;
  logic [7:0]  dm_addr;
  logic [7:0]  dm_di;
  logic [7:0]  dm_dout;
  logic        busy;
  logic        finished;
  logic        timeout;
  logic [15:0] cycle_cnt;

  logic [7:0]  mem [256];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  logic [7:0]  rd_q [$];
  logic [17:0] run_q [$];
  int          lat_q [$];
  logic        fin_p = 1'b0;
  logic        tout_p = 1'b0;
  logic        cr_p = 1'b1;

  dmem_run_ctrl #(
    .AW(8), .DW(8), .CW(16), .MAX_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .core_rst(core_rst), .core_done(core_done), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_di(dm_di), .dm_dout(dm_dout),
    .busy(busy), .finished(finished), .timeout(timeout), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  end
  assign dm_dout = mem[dm_addr];
  always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_di;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: scores outputs whenever the DUT presents them
  always @(negedge clk) begin
    if (host_gnt && !host_we) begin
      if (rd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected actual=%0h expected=none", host_rdata);
      end else begin
        chk("host_rdata", 32'(host_rdata), 32'(rd_q.pop_front()));
      end
    end
    if ((finished && !fin_p) || (timeout && !tout_p)) begin
      if (run_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL run_unexpected actual=%0h expected=none", {finished, timeout, cycle_cnt});
      end else begin
        chk("run_result{fin,tout,cnt}", 32'({finished, timeout, cycle_cnt}), 32'(run_q.pop_front()));
      end
    end
    if (!core_rst && cr_p) begin
      if (lat_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL core_start_unexpected actual=%0d expected=none", cyc - start_cyc);
      end else begin
        chk("start_latency", 32'(cyc - start_cyc), 32'(lat_q.pop_front()));
      end
    end
    fin_p  = finished;
    tout_p = timeout;
    cr_p   = core_rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    #1;
    chk("wr_gnt", 32'(host_gnt), 32'd1);
    chk("wr_dm_we", 32'(dm_we), 32'd1);
    tick();
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, input logic [7:0] e);
    rd_q.push_back(e);
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    #1;
    chk("rd_gnt", 32'(host_gnt), 32'd1);
    tick();
    host_req = 1'b0;
  endtask

  // Pulse start; returns in the first RUN cycle
  task automatic do_start();
    start = 1'b1; start_cyc = cyc; lat_q.push_back(2);
    tick();
    start = 1'b0;
    #1;
    chk("prime_busy", 32'(busy), 32'd1);
    chk("prime_core_rst", 32'(core_rst), 32'd1);
    chk("prime_flags", 32'({finished, timeout}), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    #1 reset = 1'b0;
    #1;
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Preload and read back
    host_write(8'h10, 8'hA5);
    host_write(8'h11, 8'h3C);
    host_read(8'h10, 8'hA5);
    host_read(8'h11, 8'h3C);

    // Run with core reads, contention, done on RUN cycle 10
    run_q.push_back({1'b1, 1'b0, 16'd10});
    do_start();
    core_addr = 8'h10;
    #1;
    chk("run_core_rdata", 32'(core_rdata), 32'hA5);
    chk("run_host_rdata", 32'(host_rdata), 32'h0);
    chk("run_core_rst", 32'(core_rst), 32'd0);
    tick(); tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'h5A;
    core_we = 1'b1; core_addr = 8'h30; core_wdata = 8'h77;
    #1;
    chk("cont_host_gnt", 32'(host_gnt), 32'd0);
    chk("cont_dm_addr", 32'(dm_addr), 32'h30);
    chk("cont_dm_we", 32'(dm_we), 32'd1);
    chk("cont_dm_di", 32'(dm_di), 32'h77);
    for (int k = 4; k <= 10; k++) begin
      tick();
      core_we = 1'b0;
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    #1;
    chk("done_host_gnt", 32'(host_gnt), 32'd1);
    chk("done_core_rst", 32'(core_rst), 32'd1);
    chk("done_dm_addr", 32'(dm_addr), 32'h20);
    tick();
    host_req = 1'b0; host_we = 1'b0;
    host_read(8'h30, 8'h77);
    host_read(8'h20, 8'h5A);

    // Restart from DONE; start pulses during RUN are ignored
    run_q.push_back({1'b1, 1'b0, 16'd5});
    do_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_core_rst", 32'(core_rst), 32'd0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0; core_done = 1'b1;
    tick();
    core_done = 1'b0;

    // Watchdog: no done
    run_q.push_back({1'b0, 1'b1, 16'd16});
    do_start();
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("wd_cycles", 32'(n), 32'd16);
    chk("wd_timeout", 32'(timeout), 32'd1);

    // Done on the watchdog cycle wins
    run_q.push_back({1'b1, 1'b0, 16'd16});
    do_start();
    for (int k = 1; k < 16; k++) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    #1;
    chk("wdtie_timeout", 32'(timeout), 32'd0);
    chk("wdtie_finished", 32'(finished), 32'd1);

    // Reset mid-RUN drops the in-flight store
    do_start();
    tick(); tick();
    core_we = 1'b1; core_addr = 8'h40; core_wdata = 8'h99;
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_core_rst", 32'(core_rst), 32'd1);
    chk("mid_rst_dm_we", 32'(dm_we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1; core_we = 1'b0;
    #1;
    chk("post_rst_cnt", 32'(cycle_cnt), 32'd0);
    chk("post_rst_state", 32'({busy, finished, timeout, core_rst}), 32'b0001);
    tick();
    host_read(8'h40, 8'h00);
    host_read(8'h30, 8'h77);

    tick(); tick();
    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
    chk("run_q_empty", 32'(run_q.size()), 32'd0);
    chk("lat_q_empty", 32'(lat_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
